// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of CPU, VID and memory-side signals for mem_port_arbiter.
//               The master side drives requests and mem_rdata; the slave side is
//               the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AWIDTH = 15,
    parameter int DWIDTH = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [AWIDTH-1:0] cpu_addr;
    logic [DWIDTH-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DWIDTH-1:0] cpu_rdata;
    logic              vid_req;
    logic [AWIDTH-1:0] vid_addr;
    logic              vid_ready;
    logic [DWIDTH-1:0] vid_rdata;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [DWIDTH-1:0] mem_rdata;
    logic              busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
        input  cpu_ready, cpu_rdata, vid_ready, vid_rdata,
        input  mem_addr, mem_wdata, mem_read_enable, mem_write_enable, busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
        output cpu_ready, cpu_rdata, vid_ready, vid_rdata,
        output mem_addr, mem_wdata, mem_read_enable, mem_write_enable, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port (CPU r/w, VID read-only) arbiter for a single-port
//               data memory. Round-robin on ties; define
//               MEM_ARB_FIXED_PRIORITY_EN to make the CPU always win a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AWIDTH       = 15,
    parameter int DWIDTH       = 32,
    parameter int READ_LATENCY = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_cnt_load = 4'(READ_LATENCY - 1);

    state_t            r_state;
    logic              r_win_vid;
    logic [3:0]        r_cnt;
    logic [AWIDTH-1:0] r_mem_addr;
    logic [DWIDTH-1:0] r_mem_wdata;
    logic              r_mem_re;
    logic              r_mem_we;
    logic              r_cpu_ready;
    logic              r_vid_ready;
    logic [DWIDTH-1:0] r_cpu_rdata;
    logic [DWIDTH-1:0] r_vid_rdata;
    logic              r_busy;
    logic              w_grant_vid;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    assign w_grant_vid = bus.vid_req & ~bus.cpu_req;
`else
    logic r_last_vid;

    // On a tie the requester that did not win last time is granted.
    assign w_grant_vid = bus.vid_req & (~bus.cpu_req | ~r_last_vid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_vid <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_last_vid <= r_win_vid;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_win_vid   <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cpu_ready <= 1'b0;
            r_vid_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_req | bus.vid_req) begin
                        // The memory-side registers double as the latched request.
                        r_win_vid   <= w_grant_vid;
                        r_mem_addr  <= w_grant_vid ? bus.vid_addr : bus.cpu_addr;
                        r_mem_wdata <= w_grant_vid ? '0 : bus.cpu_wdata;
                        r_mem_we    <= ~w_grant_vid & bus.cpu_we;
                        r_mem_re    <= w_grant_vid | ~bus.cpu_we;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mem_re <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (r_mem_we) begin
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_cpu_ready <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt   <= c_cnt_load;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (r_win_vid) begin
                            r_vid_rdata <= bus.mem_rdata;
                            r_vid_ready <= 1'b1;
                        end else begin
                            r_cpu_rdata <= bus.mem_rdata;
                            r_cpu_ready <= 1'b1;
                        end
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_cpu_ready <= 1'b0;
                    r_vid_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr         = r_mem_addr;
    assign bus.mem_wdata        = r_mem_wdata;
    assign bus.mem_read_enable  = r_mem_re;
    assign bus.mem_write_enable = r_mem_we;
    assign bus.cpu_ready        = r_cpu_ready;
    assign bus.vid_ready        = r_vid_ready;
    assign bus.cpu_rdata        = r_cpu_rdata;
    assign bus.vid_rdata        = r_vid_rdata;
    assign bus.busy             = r_busy;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor load/store path (CPU, read/write) and a video/peripheral fetch port (VID, read-only).
- Sits between the load/store address/data mux outputs and the memory's addr/data/read_enable/write_enable pins.
- Sequences each access through issue, read latency and completion, and returns read data with a one-cycle ready pulse.

Parameters:
- AWIDTH, 15, memory address width.
- DWIDTH, 32, data width.
- READ_LATENCY, 1, cycles from the read-enable cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request; level, sampled only in IDLE.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  AWIDTH  CPU address.
- cpu_wdata  input  DWIDTH  CPU write data.
- cpu_ready  output  1  one-cycle completion pulse.
- cpu_rdata  output  DWIDTH  last CPU read data, held between reads.
- vid_req  input  1  VID read request.
- vid_addr  input  AWIDTH  VID address.
- vid_ready  output  1  one-cycle completion pulse.
- vid_rdata  output  DWIDTH  last VID read data, held between reads.
- mem_addr  output  AWIDTH  memory address.
- mem_wdata  output  DWIDTH  memory write data.
- mem_read_enable  output  1  memory read strobe.
- mem_write_enable  output  1  memory write strobe.
- mem_rdata  input  DWIDTH  memory read data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; last_grant = VID.
- Registers: every output is driven from registers or state decode, with no combinational path from inputs to outputs.

State machine (IDLE, ISSUE, WAIT, DONE):
- IDLE:
  - If any req is high, pick a winner and latch its id, addr, we and wdata. VID is always a read.
  - Go to ISSUE. With no req, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_wdata come from the latched values.
  - mem_write_enable = latched we; mem_read_enable = !latched we.
  - Write: go to DONE. Read: load the counter with READ_LATENCY-1 and go to WAIT.
- WAIT:
  - mem_addr is held; both enables are 0.
  - Counter reaches 0: capture mem_rdata into the winner's rdata register at that edge and go to DONE. Otherwise decrement.
- DONE (1 cycle):
  - Winner's ready = 1; update last_grant to the winner; go to IDLE.

Timing:
- Outside ISSUE and WAIT: mem_addr = 0, mem_wdata = 0, enables = 0.
- Taking request sampling edge as cycle 0: ISSUE is cycle 1.
- Write ready: cycle 2.
- Read ready: cycle READ_LATENCY+2.
- Minimum request spacing is one IDLE cycle between transactions. A requester that holds req high is re-arbitrated in the IDLE cycle after DONE.

Arbitration:
- A single requester is always granted.
- On a tie, grant the requester that was not last_grant. The first tie after reset therefore goes to CPU.

Boundary rules:
- req dropped after the IDLE sample: the transaction still completes and ready still pulses.
- addr/wdata changes after the sample are ignored.
- Only the winner's rdata register updates; the other holds its value. A write never changes cpu_rdata.
- ready is never asserted to both requesters in the same cycle.
- Reset mid-transaction: immediate return to IDLE, all outputs 0, and both rdata registers cleared. The transaction is dropped with no ready, and the requester must reissue.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIORITY_EN.
- Defined: CPU always wins a tie and last_grant is ignored. VID is granted only when cpu_req is low in IDLE.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Reset: assert reset mid-simulation -> all outputs 0 immediately (asynchronous), busy=0; hold with no req -> no enables ever asserted.
- CPU write, cpu_addr=0x0010, cpu_wdata=0xDEADBEEF -> cycle 1: mem_write_enable=1, mem_addr=0x0010, mem_wdata=0xDEADBEEF for exactly 1 cycle, mem_read_enable=0; cycle 2: cpu_ready=1; cpu_rdata unchanged.
- CPU read with READ_LATENCY=2, cpu_addr=0x0123, memory model returns 0x12345678 two cycles after the strobe -> mem_read_enable=1 only in cycle 1, mem_addr=0x0123 through cycle 3; cycle 4: cpu_ready=1, cpu_rdata=0x12345678; vid_rdata unchanged.
- cpu_req and vid_req both held high, 6 transactions -> ready order CPU,VID,CPU,VID,CPU,VID; with MEM_ARB_FIXED_PRIORITY_EN, six CPU completions and vid_ready never asserted.
- Reset asserted during WAIT of a VID read -> no vid_ready, vid_rdata=0, busy=0; after release, reissued vid_req at 0x7FFF completes normally with mem_addr=0x7FFF.
- cpu_req pulsed for a single cycle with cpu_addr changed the next cycle -> transaction completes using the originally sampled address, and cpu_ready pulses once.
